// File: rtl/block_seq_pkg.sv
// Shared types and helpers for the block-slot sequencer.
package block_seq_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } seq_state_e;

  // Width of the dwell counter. It must hold 0..DWELL-1 and be at least one
  // bit, so DWELL = 1 still gets a real (constant-zero) register.
  function automatic int dwell_cnt_width(input int dwell);
    int w;
    w = (dwell <= 1) ? 1 : $clog2(dwell);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating dwell counter. Counts enabled cycles from zero up to DWELL-1 and
// then holds there; expired is decoded from the registered count only.
module dwell_timer
  import block_seq_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int                 CNT_W   = dwell_cnt_width(DWELL);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over enable; saturate at DWELL-1.
  always_comb begin
    // NOTE: assign a default to every always_comb output before any branch;
    // a path that leaves it unassigned would infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_MAX);

endmodule

// File: rtl/block_sequencer.sv
// Block-slot sequencer: presents indices 1..NUM_BLOCKS one at a time with a
// minimum dwell per index, optional consumer acknowledge, and one-shot or
// looping operation. Abort beats Hold, Hold beats Ack/dwell. All outputs are
// registered so no input reaches an output combinationally.
module block_sequencer
  import block_seq_pkg::*;
#(
  parameter int NUM_BLOCKS = 5,
  parameter int DWELL      = 1,
  parameter int ACK_MODE   = 0,
  parameter int IDX_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Abort,
  input  logic             Hold,
  input  logic             Ack,
  input  logic             loop_en,
  output logic [IDX_W-1:0] block_ready,
  output logic             block_valid,
  output logic             done,
  output logic             wrapped
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BLOCKS);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             wrapped_q, wrapped_d;

  logic dwell_done;
  logic ack_ok;
  logic adv;
  logic start;

  // Dwell timer is cleared on every index change and on leaving/entering
  // the sequence, and frozen while Hold is high.
  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (adv | start | Abort),
    .en      (!Hold),
    .expired (dwell_done)
  );

  // Acknowledge gating: in auto mode the consumer is not consulted at all.
  assign ack_ok = (ACK_MODE == 0) || Ack;

  // Advance only from S_ACTIVE once the dwell has elapsed; Hold or Abort
  // block it, and an early Ack is simply dropped.
  assign adv = (state_q == S_ACTIVE) && dwell_done && !Hold && ack_ok && !Abort;

  // Next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wrapped_d = 1'b0;
    start     = 1'b0;

    if (Abort) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Run) begin
            start   = 1'b1;
            state_d = S_ACTIVE;
            idx_d   = FIRST_IDX;
          end
        end
        S_ACTIVE: begin
          if (adv) begin
            if (idx_q != LAST_IDX) begin
              idx_d = idx_q + 1'b1;
            end else if (loop_en) begin
              // loop_en only matters on this final-index advance edge.
              idx_d     = FIRST_IDX;
              wrapped_d = 1'b1;
            end else begin
              // idx stays at LAST_IDX so block_ready keeps showing it in S_DONE.
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Wait for Run to drop so a level-held Run cannot restart the run.
          if (!Run) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end

    valid_d = (state_d == S_ACTIVE);
    done_d  = (state_d == S_DONE);
  end

  // Single state/output register bank with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  // idx is 0 in S_IDLE and NUM_BLOCKS in S_DONE, so it is block_ready directly.
  assign block_ready = idx_q;
  assign block_valid = valid_q;
  assign done        = done_q;
  assign wrapped     = wrapped_q;

endmodule

// File: tb/tb_block_sequencer.sv
// Testbench for block_sequencer: five parameter sets share one stimulus
// stream and are compared every cycle against a behavioural model, with
// directed sequences for reset, dwell/hold, ack, loop and async reset.
module tb_block_sequencer;

  localparam int N_DUT = 5;
  localparam int NB_P [N_DUT] = '{5, 5, 5, 3, 1};
  localparam int DW_P [N_DUT] = '{1, 3, 2, 1, 2};
  localparam int AM_P [N_DUT] = '{0, 0, 1, 0, 1};

  logic Clk;
  logic Reset;
  logic run, abort, hold, ack, loop_en;

  logic [31:0] br_x [N_DUT];
  logic        bv_x [N_DUT];
  logic        dn_x [N_DUT];
  logic        wr_x [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int W = $clog2(NB_P[g] + 1);
    logic [W-1:0] br;
    logic         bv, dn, wr;

    block_sequencer #(
      .NUM_BLOCKS (NB_P[g]),
      .DWELL      (DW_P[g]),
      .ACK_MODE   (AM_P[g])
    ) u_dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Run         (run),
      .Abort       (abort),
      .Hold        (hold),
      .Ack         (ack),
      .loop_en     (loop_en),
      .block_ready (br),
      .block_valid (bv),
      .done        (dn),
      .wrapped     (wr)
    );

    assign br_x[g] = 32'(br);
    assign bv_x[g] = bv;
    assign dn_x[g] = dn;
    assign wr_x[g] = wr;
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = idle, 1 = presenting an index, 2 = finished.
  // m_served counts non-Hold cycles already spent on the current index.
  int m_phase  [N_DUT];
  int m_idx    [N_DUT];
  int m_served [N_DUT];
  bit m_wrap   [N_DUT];

  task automatic model_reset();
    for (int k = 0; k < N_DUT; k++) begin
      m_phase[k] = 0; m_idx[k] = 0; m_served[k] = 0; m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < N_DUT; k++) begin
      m_wrap[k] = 1'b0;
      if (abort) begin
        m_phase[k] = 0;
        m_idx[k]   = 0;
      end else if (m_phase[k] == 0) begin
        if (run) begin
          m_phase[k] = 1; m_idx[k] = 1; m_served[k] = 0;
        end
      end else if (m_phase[k] == 1) begin
        if (m_served[k] >= DW_P[k] - 1 && !hold && (AM_P[k] == 0 || ack)) begin
          m_served[k] = 0;
          if (m_idx[k] < NB_P[k]) m_idx[k]++;
          else if (loop_en) begin m_idx[k] = 1; m_wrap[k] = 1'b1; end
          else m_phase[k] = 2;
        end else if (!hold) begin
          m_served[k]++;
        end
      end else begin
        if (!run) begin m_phase[k] = 0; m_idx[k] = 0; end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < N_DUT; k++) begin
      int exp_br;
      exp_br = (m_phase[k] == 0) ? 0 : (m_phase[k] == 1) ? m_idx[k] : NB_P[k];
      check($sformatf("u%0d.block_ready", k), br_x[k], 32'(exp_br));
      check($sformatf("u%0d.block_valid", k), {31'b0, bv_x[k]}, 32'(m_phase[k] == 1));
      check($sformatf("u%0d.done", k), {31'b0, dn_x[k]}, 32'(m_phase[k] == 2));
      check($sformatf("u%0d.wrapped", k), {31'b0, wr_x[k]}, {31'b0, m_wrap[k]});
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called at posedge+1: asserts Reset mid-cycle, checks outputs cleared
  // without a clock edge, then releases before the next edge.
  task automatic do_reset();
    #2 Reset = 1'b1;
    model_reset();
    #1 compare_all();
    #2 Reset = 1'b0;
  endtask

  int exp_hold_br [9] = '{1, 1, 1, 2, 2, 2, 2, 2, 3};
  int ack_seq     [9] = '{0, 1, 1, 0, 1, 0, 1, 1, 0};
  int hold_seq    [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  int exp_ack_br  [9] = '{1, 1, 2, 2, 2, 2, 3, 0, 1};
  int exp_ack_bv  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
  int exp_loop_br [7] = '{1, 2, 3, 1, 2, 3, 1};
  int exp_loop_wr [7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    Reset = 1'b1;
    run = 1'b0; abort = 1'b0; hold = 1'b0; ack = 1'b0; loop_en = 1'b0;
    model_reset();
    #1 compare_all();
    #10 compare_all();
    #1 Reset = 1'b0;

    // Auto mode, DWELL=1: 1..5 on consecutive edges, then S_DONE holding 5.
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("auto br e%0d", i - 1), br_x[0], 32'((i < 5) ? i : 5));
      check($sformatf("auto done e%0d", i - 1), {31'b0, dn_x[0]}, 32'(i >= 6));
    end
    run = 1'b0;
    tick();
    check("auto br after run low", br_x[0], 32'd0);
    check("auto done after run low", {31'b0, dn_x[0]}, 32'd0);

    // DWELL=3 with two Hold cycles during index 2.
    do_reset();
    run = 1'b1;
    for (int e = 0; e < 9; e++) begin
      hold = (e == 4 || e == 5);
      tick();
      check($sformatf("hold br e%0d", e), br_x[1], 32'(exp_hold_br[e]));
    end
    hold = 1'b0;

    // Ack mode, DWELL=2: early Ack dropped, Ack under Hold dropped, then Abort.
    do_reset();
    run = 1'b1;
    for (int e = 0; e < 9; e++) begin
      ack   = ack_seq[e][0];
      hold  = hold_seq[e][0];
      abort = (e == 7);
      tick();
      check($sformatf("ack br e%0d", e), br_x[2], 32'(exp_ack_br[e]));
      check($sformatf("ack valid e%0d", e), {31'b0, bv_x[2]}, 32'(exp_ack_bv[e]));
    end
    ack = 1'b0; hold = 1'b0; abort = 1'b0;

    // Looping, N=3, DWELL=1.
    do_reset();
    run = 1'b1; loop_en = 1'b1;
    for (int e = 0; e < 7; e++) begin
      tick();
      check($sformatf("loop br e%0d", e), br_x[3], 32'(exp_loop_br[e]));
      check($sformatf("loop wrapped e%0d", e), {31'b0, wr_x[3]}, 32'(exp_loop_wr[e]));
    end
    loop_en = 1'b0;

    // Asynchronous Reset at index 4, then restart.
    do_reset();
    run = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    check("async pre-reset br", br_x[0], 32'd4);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check("async reset br", br_x[0], 32'd0);
    check("async reset valid", {31'b0, bv_x[0]}, 32'd0);
    compare_all();
    #2 Reset = 1'b0;
    tick();
    check("async restart br", br_x[0], 32'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      run   = ($urandom_range(99) < 75);
      abort = ($urandom_range(99) < 3);
      hold  = ($urandom_range(99) < 20);
      ack   = ($urandom_range(99) < 50);
      if ($urandom_range(99) < 10) loop_en = 1'($urandom_range(1));
      if ($urandom_range(999) < 4) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_sequencer.md
# block_sequencer

Parametrised block-slot sequencer for the final-project datapath. It issues block indices 1..NUM_BLOCKS to the block-drawing/loading logic one at a time, with three controls: a programmable minimum dwell per block, an optional consumer acknowledge, and a one-shot or looping mode. It sits between top-level game control (Run/Abort/Hold) and the per-block consumers that decode `block_ready`.

## Interface
Parameters:
- NUM_BLOCKS, 5: number of block slots; must be ≥1.
- DWELL, 1: minimum cycles each index is presented; must be ≥1.
- ACK_MODE, 0: 0 = advance automatically after the dwell; 1 = also require Ack.
- IDX_W, $clog2(NUM_BLOCKS+1): index width (derived; not overridden).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  level start request.
- Abort  in  1  synchronous return to idle; highest priority.
- Hold  in  1  freezes the dwell count and advancement.
- Ack  in  1  consumer acknowledge for the current index (used only when ACK_MODE=1).
- loop_en  in  1  when 1, wrap from NUM_BLOCKS back to 1 instead of finishing.
- block_ready  out  IDX_W  current index; 0 = none.
- block_valid  out  1  high while in S_ACTIVE.
- done  out  1  high while in S_DONE.
- wrapped  out  1  one-cycle pulse on the first cycle of index 1 after a wrap.

## Operation
- **States:** S_IDLE, S_ACTIVE, S_DONE.
- **Reset values:**
  - state = S_IDLE.
  - idx = 0, dwell count = 0.
  - All outputs 0.
- **S_IDLE:**
  - block_ready = 0.
  - If Run = 1 and Abort = 0: go to S_ACTIVE with idx = 1 and dwell count = 0.
- **S_ACTIVE:**
  - block_ready = idx; block_valid = 1.
  - dwell_done = (count == DWELL-1).
  - The count increments each non-Hold cycle and saturates at DWELL-1.
  - adv = dwell_done & !Hold & (ACK_MODE==0 | Ack).
  - On adv with idx < NUM_BLOCKS: idx++ and the count clears.
  - On adv with idx == NUM_BLOCKS:
    - loop_en = 1: idx = 1, count clears, wrapped = 1 next cycle.
    - loop_en = 0: go to S_DONE.
- **S_DONE:**
  - block_ready = NUM_BLOCKS; done = 1; block_valid = 0.
  - Go to S_IDLE when Run = 0, so a held Run never retriggers.
- **Abort:** in any state, the next state is S_IDLE with idx = 0.
- **Priority:** Abort > Hold > Ack/dwell.
- **Ack handling:**
  - Ack while Hold = 1, before dwell_done, or outside S_ACTIVE is ignored and not remembered.
  - Ack is ignored when ACK_MODE = 0.
- **Mid-operation changes:**
  - loop_en is sampled only at the final-index advance edge.
  - Run going low during S_ACTIVE has no effect.
- **NUM_BLOCKS = 1 with loop_en:** idx stays 1, and wrapped pulses after every advance.
- **Asynchronous Reset mid-sequence:** immediate return to the reset values.

## Timing
- **Start latency:** Run sampled high at edge k in S_IDLE gives block_ready = 1 from edge k onward, i.e. one cycle.
- **Auto mode (ACK_MODE=0, no Hold):** each index is presented exactly DWELL cycles. DWELL = 1 gives 1,2,…,N on consecutive cycles, then S_DONE holding N.
- **Ack mode:**
  - Advance occurs at the first edge where dwell_done & Ack & !Hold.
  - With DWELL = 1, Ack high in the first cycle of an index advances at that edge.
- **Hold:** each Hold cycle extends the current index by exactly one cycle.
- **Outputs:** all are registered or decoded from registered state only; no combinational path from inputs to outputs.
- **wrapped:** coincides with the first cycle of block_ready = 1 after a wrap.

## Structure
- Package `block_seq_pkg`:
  - state enum (S_IDLE, S_ACTIVE, S_DONE) as logic [1:0];
  - localparam function for counter width, max(1, $clog2(DWELL)).
- Sub-module `dwell_timer`:
  - parameter DWELL;
  - inputs clr, en;
  - output expired;
  - saturating counter.
- Top FSM instantiates one dwell_timer, with clr = adv | start | Abort and en = !Hold.

## Test plan
- **Reset, then Run = 1 for 8 cycles (N=5, DWELL=1, ACK_MODE=0, loop_en=0):** block_ready = 1,2,3,4,5,5,5…; done = 1 from the 5th edge; drop Run → next edge block_ready = 0.
- **DWELL = 3, Hold = 1 for 2 cycles during index 2:** index 1 lasts 3 cycles, index 2 lasts 5 cycles, index 3 starts at edge 8.
- **ACK_MODE = 1, DWELL = 2:**
  - Ack in the first cycle of index 1 is ignored.
  - Ack in the 2nd cycle advances to 2.
  - Ack with Hold = 1 does not advance.
- **loop_en = 1, N = 3, DWELL = 1:** block_ready = 1,2,3,1,2,3; wrapped = 1 on exactly both cycles where block_ready returns to 1 after 3.
- **Abort at index 3 together with Ack (ACK_MODE=1):** next edge block_ready = 0 and block_valid = 0; restart with Run gives block_ready = 1.
- **Async Reset asserted mid-cycle at index 4:** outputs go to 0 without waiting for Clk; the sequence restarts at 1 after Reset releases with Run = 1.
